// File: rtl/draw_pkg.sv
// Shared definitions for the block-draw path: command codes, FSM states, colours,
// screen limits and the frame-to-x mapping.
package draw_pkg;

   localparam logic [3:0] CMD_FRAME_FIRST = 4'd0;
   localparam logic [3:0] CMD_FRAME_LAST  = 4'd14;
   localparam logic [3:0] CMD_BLACK       = 4'd15;

   localparam logic [2:0] COLOUR_BLACK = 3'b000;

   localparam int X_MAX = 159;
   localparam int Y_MAX = 119;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ERASE = 2'd1,
      DRAW  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Left edge of the block for a frame index; 8-bit arithmetic.
   function automatic logic [7:0] frame_x(input logic [3:0] cmd,
                                          input logic [7:0] x_start,
                                          input logic [7:0] x_step);
      return x_start + ({4'b0000, cmd} * x_step);
   endfunction

endpackage

// File: rtl/draw_block_executor_rect_scanner.sv
// Walks a W x H rectangle one pixel per cycle, cx inner and cy outer.
// start restarts the scan at (0,0) even if a scan is still running.
module rect_scanner #(
   parameter int W = 8,
   parameter int H = 8
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       start,
   output logic [3:0] cx,
   output logic [3:0] cy,
   output logic       active,
   output logic       last
);

   localparam logic [3:0] CX_LAST = 4'(W - 1);
   localparam logic [3:0] CY_LAST = 4'(H - 1);

   logic [3:0] cx_q, cx_d;
   logic [3:0] cy_q, cy_d;
   logic       active_q, active_d;

   assign last = active_q && (cx_q == CX_LAST) && (cy_q == CY_LAST);

   always_comb begin
      cx_d     = cx_q;
      cy_d     = cy_q;
      active_d = active_q;
      if (start) begin
         cx_d     = 4'd0;
         cy_d     = 4'd0;
         active_d = 1'b1;
      end else if (last) begin
         // Park at the origin so nothing out of range is ever presented.
         cx_d     = 4'd0;
         cy_d     = 4'd0;
         active_d = 1'b0;
      end else if (active_q) begin
         if (cx_q == CX_LAST) begin
            cx_d = 4'd0;
            cy_d = cy_q + 4'd1;
         end else begin
            cx_d = cx_q + 4'd1;
         end
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         cx_q     <= 4'd0;
         cy_q     <= 4'd0;
         active_q <= 1'b0;
      end else begin
         cx_q     <= cx_d;
         cy_q     <= cy_d;
         active_q <= active_d;
      end
   end

   assign cx     = cx_q;
   assign cy     = cy_q;
   assign active = active_q;

endmodule

// File: rtl/draw_block_executor.sv
// Executes 4-bit draw commands: erases the previous note block, draws the new one,
// one pixel per cycle. Define FRAME_COUNT_EN to add the frame_count output.
module draw_block_executor
   import draw_pkg::*;
#(
   parameter logic [7:0] X_START     = 8'd8,
   parameter logic [7:0] X_STEP      = 8'd10,
   parameter logic [6:0] Y_POS       = 7'd60,
   parameter int         BLK_W       = 8,
   parameter int         BLK_H       = 8,
   parameter logic [2:0] NOTE_COLOUR = 3'b100
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic [3:0] command,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
`ifdef FRAME_COUNT_EN
   output logic [15:0] frame_count,
`endif
   output logic       done
);

   // Handshake: a command is taken on a rising edge with cmd_valid & cmd_ready;
   // cmd_ready is high only in IDLE and nothing is queued while busy.
   state_t     state_q, state_d;
   logic [3:0] cmd_q;
   logic [7:0] new_pos_q;
   logic [7:0] cur_pos_q;
   logic       has_block_q;

   logic       accept;
   logic       scan_start;
   logic [3:0] scan_cx, scan_cy;
   logic       scan_active, scan_last;
   logic       plotting;
   logic [7:0] base_x;

   rect_scanner #(.W(BLK_W), .H(BLK_H)) u_scan (
      .CLK    (CLK),
      .reset  (reset),
      .start  (scan_start),
      .cx     (scan_cx),
      .cy     (scan_cy),
      .active (scan_active),
      .last   (scan_last)
   );

   assign accept = cmd_valid && (state_q == IDLE);

   always_comb begin
      state_d    = state_q;
      scan_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (has_block_q) begin
                  state_d    = ERASE;
                  scan_start = 1'b1;
               end else if (command == CMD_BLACK) begin
                  state_d = DONE;
               end else begin
                  state_d    = DRAW;
                  scan_start = 1'b1;
               end
            end
         end
         ERASE: begin
            if (scan_last) begin
               if (cmd_q == CMD_BLACK) begin
                  state_d = DONE;
               end else begin
                  state_d    = DRAW;
                  scan_start = 1'b1;
               end
            end
         end
         DRAW: begin
            if (scan_last) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cmd_q       <= 4'd0;
         new_pos_q   <= 8'd0;
         cur_pos_q   <= 8'd0;
         has_block_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cmd_q     <= command;
            new_pos_q <= frame_x(command, X_START, X_STEP);
         end
         // A finished erase always leaves the screen empty; a finished draw owns it.
         if (state_q == ERASE && scan_last) has_block_q <= 1'b0;
         if (state_q == DRAW && scan_last) begin
            has_block_q <= 1'b1;
            cur_pos_q   <= new_pos_q;
         end
      end
   end

`ifdef FRAME_COUNT_EN
   logic [15:0] frame_count_q;

   // Every non-Black command reaches DONE through DRAW.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         frame_count_q <= 16'd0;
      end else if (state_q == DONE && cmd_q != CMD_BLACK) begin
         frame_count_q <= frame_count_q + 16'd1;
      end
   end

   assign frame_count = frame_count_q;
`endif

   assign plotting  = ((state_q == ERASE) || (state_q == DRAW)) && scan_active;
   assign base_x    = (state_q == ERASE) ? cur_pos_q : new_pos_q;

   assign x         = plotting ? (base_x + {4'b0000, scan_cx}) : 8'd0;
   assign y         = plotting ? (Y_POS + {3'b000, scan_cy}) : 7'd0;
   assign colour    = (plotting && state_q == DRAW) ? NOTE_COLOUR : COLOUR_BLACK;
   assign plot      = plotting;
   assign done      = (state_q == DONE);
   assign cmd_ready = (state_q == IDLE);

endmodule

// File: tb/tb_draw_block_executor.sv
// Self-checking bench for draw_block_executor: directed steps plus random commands
// against a pixel-list reference model.
module tb_draw_block_executor;

   localparam int BW      = 8;
   localparam int BH      = 8;
   localparam int XSTART  = 8;
   localparam int XSTEP   = 10;
   localparam int YPOS    = 60;
   localparam int NOTE    = 4;

   logic       CLK = 1'b0;
   logic       reset;
   logic [3:0] command;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [17:0] exp_q[$];
   bit          m_has;
   int          m_pos;

   draw_block_executor dut (
      .CLK       (CLK),
      .reset     (reset),
      .command   (command),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .x         (x),
      .y         (y),
      .colour    (colour),
      .plot      (plot),
      .done      (done)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_block(input int base, input int col);
      for (int cy = 0; cy < BH; cy++)
         for (int cx = 0; cx < BW; cx++)
            exp_q.push_back({8'(base + cx), 7'(YPOS + cy), 3'(col)});
   endtask

   // Expected pixel list and done latency for one command, from the block rules.
   task automatic model_cmd(input int cmd, output int exp_done);
      exp_q.delete();
      if (m_has) push_block(m_pos, 0);
      if (cmd == 15) begin
         m_has = 1'b0;
      end else begin
         m_pos = XSTART + cmd * XSTEP;
         push_block(m_pos, NOTE);
         m_has = 1'b1;
      end
      exp_done = exp_q.size() + 1;
   endtask

   task automatic sample_pixel();
      logic [17:0] e;
      if (plot) begin
         if (exp_q.size() == 0) begin
            check("extra_plot", {x, y, colour}, 18'h0);
         end else begin
            e = exp_q.pop_front();
            check("pixel", {x, y, colour}, e);
         end
      end
   endtask

   // pulse_at > 0 raises cmd_valid (cmd 5) for one edge while the command is busy.
   task automatic run_cmd(input int cmd, input int pulse_at);
      int exp_done;
      int got_done;
      got_done = -1;
      model_cmd(cmd, exp_done);
      @(negedge CLK);
      check("ready_before", cmd_ready, 1);
      command   = 4'(cmd);
      cmd_valid = 1'b1;
      @(negedge CLK);
      cmd_valid = 1'b0;
      command   = 4'($urandom_range(0, 15));
      check("busy", cmd_ready, 0);
      for (int n = 1; n <= 400; n++) begin
         if (n > 1) @(negedge CLK);
         sample_pixel();
         if (done) begin
            got_done = n;
            break;
         end
         cmd_valid = (n == pulse_at);
         if (n == pulse_at) command = 4'd5;
      end
      cmd_valid = 1'b0;
      check("done_cycle", got_done, exp_done);
      check("plots_left", exp_q.size(), 0);
      @(negedge CLK);
      check("ready_after", cmd_ready, 1);
      check("done_pulse", done, 0);
   endtask

   initial begin
      int exp_done;
      int c;
      reset     = 1'b1;
      command   = 4'd0;
      cmd_valid = 1'b0;
      m_has     = 1'b0;
      m_pos     = 0;
      repeat (3) @(negedge CLK);
      check("rst_ready", cmd_ready, 1);
      check("rst_plot", plot, 0);
      check("rst_done", done, 0);
      check("rst_xyc", {x, y, colour}, 18'h0);
      reset = 1'b0;

      run_cmd(0, 0);
      run_cmd(1, 0);
      run_cmd(15, 0);
      run_cmd(15, 0);
      run_cmd(4, 30);
      run_cmd(4, 100);
      run_cmd(7, 0);

      // Abort a draw of frame 14 with an asynchronous reset.
      run_cmd(15, 0);
      model_cmd(14, exp_done);
      @(negedge CLK);
      command   = 4'd14;
      cmd_valid = 1'b1;
      @(negedge CLK);
      cmd_valid = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         if (n > 1) @(negedge CLK);
         sample_pixel();
      end
      check("abort_plotting", plot, 1);
      #2 reset = 1'b1;
      #1;
      check("abort_plot", plot, 0);
      check("abort_ready", cmd_ready, 1);
      check("abort_done", done, 0);
      m_has = 1'b0;
      exp_q.delete();
      @(negedge CLK);
      reset = 1'b0;
      run_cmd(3, 0);

      for (int i = 0; i < 25; i++) begin
         c = ($urandom_range(0, 4) == 0) ? 15 : int'($urandom_range(0, 14));
         run_cmd(c, ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 60)) : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
